// File: rtl/daisy_chain_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : daisy_chain_irq_controller
//  Purpose  : Interrupt controller for an active-low daisy-chain priority
//             chain. Synchronises the wired-OR chain request, raises a CPU
//             interrupt, drives the chain-head acknowledge when the CPU
//             acknowledges, priority-encodes which link took the acknowledge
//             into a vector, then releases the chain for a recovery period.
//             Link 0 is nearest the chain head (highest priority).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock
//    reset       in   asynchronous active-high reset
//    enable      in   gates acceptance of new requests (IDLE only)
//    irq_n       in   active-low wired-OR chain request (asynchronous)
//    ack_k_n     in   [N]  per-link active-low "acknowledge taken"
//    ack_tail_n  in   active-low acknowledge leaving the chain tail
//    cpu_inta    in   CPU interrupt acknowledge (level, honoured in REQ)
//    ack_n       out  active-low acknowledge into the chain head
//    cpu_irq     out  active-high interrupt to the CPU
//    vec         out  [VW] index of the acknowledged link
//    vec_valid   out  one-cycle strobe qualifying vec
//    spurious    out  one-cycle strobe when no link took the acknowledge
//    busy        out  high whenever the controller is not idle
// ============================================================================
module daisy_chain_irq_controller #(
   parameter int N          = 4,
   parameter int VW         = 2,
   parameter int ACK_SETTLE = 2,
   parameter int RECOVER    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          irq_n,
   input  logic [N-1:0]  ack_k_n,
   input  logic          ack_tail_n,
   input  logic          cpu_inta,
   output logic          ack_n,
   output logic          cpu_irq,
   output logic [VW-1:0] vec,
   output logic          vec_valid,
   output logic          spurious,
   output logic          busy
);

   // One shared counter times both the settle and the recovery phases; it
   // only ever needs to reach (max phase length - 1).
   localparam int c_CNT_MAX = (ACK_SETTLE > RECOVER) ? ACK_SETTLE : RECOVER;
   localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
   localparam logic [c_CW-1:0] c_SETTLE_LAST  = c_CW'(ACK_SETTLE - 1);
   localparam logic [c_CW-1:0] c_RECOVER_LAST = c_CW'(RECOVER - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_ACK     = 3'd2,
      S_CAPTURE = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic            w_sample;

   logic            r_sync1;
   logic            r_irq_s;

   logic [VW-1:0]   r_vec;
   logic            r_vec_valid;
   logic            r_spurious;

   logic [VW-1:0]   w_enc;
   logic            w_any_taker;

   // The tail acknowledge is informational only: a missing taker alone
   // decides a spurious acknowledge, whatever the tail reports.
   logic            w_unused;
   assign w_unused = ack_tail_n;

   // ------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous chain request; idles high
   // so that reset never looks like a pending request.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_irq_s <= 1'b1;
      end else begin
         r_sync1 <= irq_n;
         r_irq_s <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Priority encoder: lowest-index link holding its ack low wins.
   // Scanning downwards lets the lowest index overwrite higher ones.
   // ------------------------------------------------------------------
   always_comb begin
      w_enc = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!ack_k_n[i]) begin
            w_enc = VW'(i);
         end
      end
   end

   assign w_any_taker = ~&ack_k_n;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. The counter is cleared on entry to ACK and RELEASE
   // so each phase counts from zero.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sample    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_irq_s && enable) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // Acknowledge wins over a simultaneous withdrawal.
            if (cpu_inta) begin
               w_state_nxt = S_ACK;
               w_cnt_nxt   = '0;
            end else if (r_irq_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACK: begin
            if (r_cnt == c_SETTLE_LAST) begin
               w_sample    = 1'b1;
               w_state_nxt = S_CAPTURE;
            end else begin
               w_cnt_nxt = r_cnt + c_CW'(1);
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
         end
         S_RELEASE: begin
            if (r_cnt == c_RECOVER_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Capture registers: the strobes are high only in the CAPTURE cycle;
   // the vector is held across a spurious acknowledge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vec       <= '0;
         r_vec_valid <= 1'b0;
         r_spurious  <= 1'b0;
      end else begin
         r_vec_valid <= w_sample & w_any_taker;
         r_spurious  <= w_sample & ~w_any_taker;
         if (w_sample && w_any_taker) begin
            r_vec <= w_enc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: registers or pure decodes of the state register.
   // ------------------------------------------------------------------
   assign ack_n     = ~((r_state == S_ACK) || (r_state == S_CAPTURE));
   assign cpu_irq   = (r_state == S_REQ);
   assign busy      = (r_state != S_IDLE);
   assign vec       = r_vec;
   assign vec_valid = r_vec_valid;
   assign spurious  = r_spurious;

endmodule
`default_nettype wire
